// File: rtl/rmii_rx_framer_if.sv
// rmii_rx_framer_if: received-frame dibit stream from the RMII framer to
// the MAC RX packet buffer.
//   rx_axi_valid : frame dibit valid
//   rx_axi_data  : frame dibit while valid; status on the cycle valid
//                  falls (2'b11 good, anything else bad); 2'b00 otherwise
// master = framer (drives), slave = packet buffer (receives).
interface rmii_rx_framer_if;
  logic       rx_axi_valid;
  logic [1:0] rx_axi_data;

  modport master (output rx_axi_valid, output rx_axi_data);
  modport slave  (input  rx_axi_valid, input  rx_axi_data);
endinterface

// File: rtl/rmii_rx_framer.sv
// rmii_rx_framer: RMII receive front-end. Strips preamble/SFD, forwards
// frame dibits (DA through FCS) with one cycle of latency, checks CRC-32,
// length and byte alignment, and reports status in-band when valid falls.
// Ports:
//   clk         : 50 MHz RMII reference clock
//   rst_n       : asynchronous active-low reset
//   crsdv       : PHY CRS_DV, used as a pure data-valid
//   rxd[1:0]    : PHY receive dibit, rxd[0] is earlier on the wire
//   rx_axi      : master side of the frame dibit stream
//   crc_err_cnt : saturating count of frames rejected only for CRC
//
// state    | meaning
// IDLE     | line quiet, waiting for the first preamble dibit
// PREAMBLE | counting 2'b01 dibits, waiting for the SFD dibit 2'b11
// DATA     | forwarding frame dibits and running the CRC
// DROP     | bad preamble or oversize frame, discard until crsdv falls
module rmii_rx_framer #(
  parameter int MIN_FRAME_BYTES     = 64,
  parameter int MAX_FRAME_BYTES     = 1518,
  parameter int MIN_PREAMBLE_DIBITS = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                crsdv,
  input  logic [1:0]          rxd,
  rmii_rx_framer_if.master    rx_axi,
  output logic [15:0]         crc_err_cnt
);

  localparam logic [12:0] MIN_DIB  = 13'(MIN_FRAME_BYTES * 4);
  localparam logic [12:0] MAX_DIB  = 13'(MAX_FRAME_BYTES * 4);
  localparam logic [3:0]  PRE_MIN  = 4'(MIN_PREAMBLE_DIBITS);
  localparam logic [31:0] POLY     = 32'hEDB88320;
  localparam logic [31:0] RESIDUE  = 32'hDEBB20E3;

  typedef enum logic [1:0] {IDLE, PREAMBLE, DATA, DROP} state_t;

  state_t      state_q, state_d;
  logic [3:0]  pre_cnt_q, pre_cnt_d;
  logic [12:0] dib_cnt_q, dib_cnt_d;
  logic [31:0] crc_q, crc_d;
  logic        valid_q, valid_d;
  logic [1:0]  data_q, data_d;
  logic [15:0] err_q, err_d;

  logic crc_ok, align_ok, len_ok;

  // Reflected CRC-32, two bits per clock, rxd[0] first.
  function automatic logic [31:0] crc_dibit(input logic [31:0] c, input logic [1:0] d);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 2; i++) begin
      if (r[0] ^ d[i]) r = (r >> 1) ^ POLY;
      else             r = r >> 1;
    end
    return r;
  endfunction

  // A frame that carried its own FCS leaves the fixed residue in the register.
  assign crc_ok   = (crc_q == RESIDUE);
  assign align_ok = (dib_cnt_q[1:0] == 2'b00);
  assign len_ok   = (dib_cnt_q >= MIN_DIB) && (dib_cnt_q <= MAX_DIB);

  always_comb begin
    state_d   = state_q;
    pre_cnt_d = pre_cnt_q;
    dib_cnt_d = dib_cnt_q;
    crc_d     = crc_q;
    err_d     = err_q;
    valid_d   = 1'b0;
    data_d    = 2'b00;
    case (state_q)
      IDLE: begin
        if (crsdv) begin
          if (rxd == 2'b01) begin
            state_d   = PREAMBLE;
            pre_cnt_d = 4'd1;
          end else begin
            state_d = DROP;
          end
        end
      end
      PREAMBLE: begin
        if (!crsdv) begin
          state_d = IDLE;
        end else if (rxd == 2'b01) begin
          if (pre_cnt_q != 4'hF) pre_cnt_d = pre_cnt_q + 4'd1;
        end else if (rxd == 2'b11 && pre_cnt_q >= PRE_MIN) begin
          state_d   = DATA;
          dib_cnt_d = '0;
          crc_d     = 32'hFFFF_FFFF;
        end else begin
          state_d = DROP;
        end
      end
      DATA: begin
        if (!crsdv) begin
          state_d = IDLE;
          if (crc_ok && align_ok && len_ok) data_d = 2'b11;
          if (!crc_ok && align_ok && len_ok && err_q != 16'hFFFF) err_d = err_q + 16'd1;
        end else if (dib_cnt_q == MAX_DIB) begin
          // Oversize: this dibit is swallowed and the abort status is 2'b00.
          state_d = DROP;
        end else begin
          valid_d   = 1'b1;
          data_d    = rxd;
          crc_d     = crc_dibit(crc_q, rxd);
          dib_cnt_d = dib_cnt_q + 13'd1;
        end
      end
      DROP: begin
        if (!crsdv) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      pre_cnt_q <= '0;
      dib_cnt_q <= '0;
      crc_q     <= 32'hFFFF_FFFF;
      err_q     <= '0;
      valid_q   <= 1'b0;
      data_q    <= 2'b00;
    end else begin
      state_q   <= state_d;
      pre_cnt_q <= pre_cnt_d;
      dib_cnt_q <= dib_cnt_d;
      crc_q     <= crc_d;
      err_q     <= err_d;
      valid_q   <= valid_d;
      data_q    <= data_d;
    end
  end

  assign rx_axi.rx_axi_valid = valid_q;
  assign rx_axi.rx_axi_data  = data_q;
  assign crc_err_cnt         = err_q;

endmodule

// File: tb/tb_rmii_rx_framer.sv
// tb_rmii_rx_framer: directed bench for rmii_rx_framer. Frames are built
// from byte lists with a reference CRC-32 FCS and driven dibit by dibit;
// every cycle the output stream is compared with the expected dibit.
module tb_rmii_rx_framer;
  localparam int MAX_DIB = 1518 * 4;

  logic        clk;
  logic        rst_n;
  logic        crsdv;
  logic [1:0]  rxd;
  logic [15:0] crc_err_cnt;

  rmii_rx_framer_if rx_if ();

  rmii_rx_framer dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .crsdv       (crsdv),
    .rxd         (rxd),
    .rx_axi      (rx_if.master),
    .crc_err_cnt (crc_err_cnt)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int n_valid  = 0;

  logic [7:0] byte_q[$];
  logic [1:0] tx_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_crc();
    logic [31:0] c;
    c = 32'hFFFF_FFFF;
    foreach (byte_q[k]) begin
      for (int b = 0; b < 8; b++) begin
        if (c[0] ^ byte_q[k][b]) c = (c >> 1) ^ 32'hEDB88320;
        else                     c = c >> 1;
      end
    end
    return ~c;
  endfunction

  // n_pre dibits of 01, SFD dibit 11, n_payload bytes, optional FCS,
  // optional single-bit flip (after the FCS is computed).
  task automatic build_frame(input int n_pre, input int n_payload, input bit add_fcs,
                             input int flip_byte);
    logic [31:0] fcs;
    logic [7:0]  b;
    byte_q = {};
    for (int i = 0; i < n_payload; i++) byte_q.push_back(8'((i * 37 + 11) & 255));
    if (add_fcs) begin
      fcs = ref_crc();
      for (int i = 0; i < 4; i++) byte_q.push_back(fcs[8*i +: 8]);
    end
    if (flip_byte >= 0) byte_q[flip_byte] = byte_q[flip_byte] ^ 8'h08;
    tx_q = {};
    for (int i = 0; i < n_pre; i++) tx_q.push_back(2'b01);
    tx_q.push_back(2'b11);
    foreach (byte_q[k]) begin
      b = byte_q[k];
      for (int d = 0; d < 4; d++) tx_q.push_back(b[2*d +: 2]);
    end
  endtask

  // Called at posedge+1. Drives n_drive dibits of tx_q; dibits past the
  // first hdr are expected on the output one cycle later when fwd is set.
  task automatic send(input string tag, input int hdr, input bit fwd,
                      input logic [1:0] st, input int n_drive, input bit close);
    logic       f;
    logic [2:0] exp;
    n_valid = 0;
    for (int i = 0; i < n_drive; i++) begin
      crsdv = 1'b1;
      rxd   = tx_q[i];
      @(posedge clk); #1;
      f   = fwd && (i >= hdr) && ((i - hdr) < MAX_DIB);
      exp = f ? {1'b1, tx_q[i]} : 3'b000;
      if (rx_if.rx_axi_valid) n_valid++;
      chk({tag, "_dibit"}, {29'd0, rx_if.rx_axi_valid, rx_if.rx_axi_data}, {29'd0, exp});
    end
    if (close) begin
      crsdv = 1'b0;
      rxd   = 2'b00;
      @(posedge clk); #1;
      chk({tag, "_status"}, {29'd0, rx_if.rx_axi_valid, rx_if.rx_axi_data}, {29'd0, 1'b0, st});
      @(posedge clk); #1;
      chk({tag, "_after"}, {29'd0, rx_if.rx_axi_valid, rx_if.rx_axi_data}, 32'd0);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    crsdv = 1'b0;
    rxd   = 2'b00;
    @(posedge clk); #1;
    chk("reset_valid", {31'd0, rx_if.rx_axi_valid}, 32'd0);
    chk("reset_data",  {30'd0, rx_if.rx_axi_data}, 32'd0);
    chk("reset_cnt",   {16'd0, crc_err_cnt}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Good 64-byte frame.
    build_frame(31, 60, 1'b1, -1);
    send("good", 32, 1'b1, 2'b11, tx_q.size(), 1'b1);
    chk("good_nvalid", n_valid, 256);
    chk("good_cnt", {16'd0, crc_err_cnt}, 32'd0);

    // Same frame with one payload bit flipped.
    build_frame(31, 60, 1'b1, 20);
    send("flip", 32, 1'b1, 2'b00, tx_q.size(), 1'b1);
    chk("flip_nvalid", n_valid, 256);
    chk("flip_cnt", {16'd0, crc_err_cnt}, 32'd1);

    // Good frame plus two dibits: misaligned, CRC counter untouched.
    build_frame(31, 60, 1'b1, -1);
    tx_q.push_back(2'b00);
    tx_q.push_back(2'b00);
    send("align", 32, 1'b1, 2'b00, tx_q.size(), 1'b1);
    chk("align_nvalid", n_valid, 258);
    chk("align_cnt", {16'd0, crc_err_cnt}, 32'd1);

    // Short preamble: nothing forwarded, then recovery.
    build_frame(4, 20, 1'b0, -1);
    send("shortpre", 5, 1'b0, 2'b00, tx_q.size(), 1'b1);
    chk("shortpre_nvalid", n_valid, 0);
    build_frame(31, 60, 1'b1, -1);
    send("recover", 32, 1'b1, 2'b11, tx_q.size(), 1'b1);
    chk("recover_nvalid", n_valid, 256);

    // 1600-byte oversize stream: 6072 dibits then abort.
    build_frame(31, 1600, 1'b0, -1);
    send("oversize", 32, 1'b1, 2'b00, tx_q.size(), 1'b1);
    chk("oversize_nvalid", n_valid, MAX_DIB);
    chk("oversize_cnt", {16'd0, crc_err_cnt}, 32'd1);
    build_frame(31, 60, 1'b1, -1);
    send("postover", 32, 1'b1, 2'b11, tx_q.size(), 1'b1);

    // Reset pulse mid-payload.
    build_frame(31, 60, 1'b1, -1);
    send("midrst", 32, 1'b1, 2'b00, 32 + 100, 1'b0);
    chk("midrst_valid_before", {31'd0, rx_if.rx_axi_valid}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("midrst_async", {29'd0, rx_if.rx_axi_valid, rx_if.rx_axi_data}, 32'd0);
    chk("midrst_cnt", {16'd0, crc_err_cnt}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    crsdv = 1'b0;
    rxd   = 2'b00;
    @(posedge clk); #1;
    chk("midrst_nostatus0", {29'd0, rx_if.rx_axi_valid, rx_if.rx_axi_data}, 32'd0);
    @(posedge clk); #1;
    chk("midrst_nostatus1", {29'd0, rx_if.rx_axi_valid, rx_if.rx_axi_data}, 32'd0);
    send("postrst", 32, 1'b1, 2'b11, tx_q.size(), 1'b1);
    chk("postrst_nvalid", n_valid, 256);
    chk("postrst_cnt", {16'd0, crc_err_cnt}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
